uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter: serialises one word per valid/ready handshake into

---
 rtl/uart_tx_frame.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start + DATA_WIDTH bits LSB first + optional parity + STOP_BITS stop bits.
// Latency: accept edge -> start bit on the line next cycle; tx_done pulses F+1 cycles after accept.
// Backpressure: tx_ready only in IDLE; UART_TX_BREAK_EN adds a tx_break line-hold state.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  parity_odd,
`ifdef UART_TX_BREAK_EN
    input  logic                  tx_break,
`endif
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BITW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]   BAUD_MAX  = BW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_WIDTH - 1);
    localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_MARK
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_baud;
    logic [BITW-1:0]       r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx_out;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [BW-1:0]         w_baud_nxt;
    logic [BW-1:0]         w_baud_inc;
    logic [BITW-1:0]       w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_par_en_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_baud_end;
    logic                  w_tx_out_nxt;

    assign w_baud_end = (r_baud == BAUD_MAX);
    assign w_baud_inc = w_baud_end ? '0 : r_baud + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        case (r_state)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    w_state_nxt = S_BREAK;
                    w_baud_nxt  = '0;
                end else
`endif
                if (tx_valid) begin
                    // Parity is folded into one bit at accept so later input changes cannot leak in
                    w_state_nxt   = S_START;
                    w_baud_nxt    = '0;
                    w_bit_nxt     = '0;
                    w_shift_nxt   = tx_data;
                    w_par_en_nxt  = parity_en;
                    w_par_bit_nxt = (^tx_data) ^ parity_odd;
                end
            end
            S_START: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_end) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (!tx_break) begin
                    w_state_nxt = S_MARK;
                    w_baud_nxt  = '0;
                end
            end
            S_MARK: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so the output register lines up with it
    always_comb begin
        w_tx_out_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_out_nxt = 1'b0;
            S_DATA:   w_tx_out_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_out_nxt = w_par_bit_nxt;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  w_tx_out_nxt = 1'b0;
`endif
            default:  w_tx_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx_out  <= w_tx_out_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (r_state == S_STOP) && (w_state_nxt == S_IDLE);
        end
    end

    assign tx_ready = (r_state == S_IDLE);
    assign tx_out   = r_tx_out;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLK_DIV=4, DATA_WIDTH=8; second instance has STOP_BITS=2.
module tb_uart_tx_frame;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_en;
    logic       parity_odd;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] d2_tx_data;
    logic       d2_tx_valid;
    logic       d2_tx_ready;
    logic       d2_parity_en;
    logic       d2_parity_odd;
    logic       d2_tx_out;
    logic       d2_tx_busy;
    logic       d2_tx_done;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
    logic       d2_tx_break;
`endif

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_frame #(.DATA_WIDTH(8), .CLK_DIV(4), .STOP_BITS(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
`ifdef UART_TX_BREAK_EN
        .tx_break   (tx_break),
`endif
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .CLK_DIV(4), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (d2_tx_data),
        .tx_valid   (d2_tx_valid),
        .tx_ready   (d2_tx_ready),
        .parity_en  (d2_parity_en),
        .parity_odd (d2_parity_odd),
`ifdef UART_TX_BREAK_EN
        .tx_break   (d2_tx_break),
`endif
        .tx_out     (d2_tx_out),
        .tx_busy    (d2_tx_busy),
        .tx_done    (d2_tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call right after the accept edge; checks cycles 1..F+1 and returns mid-bit line samples.
    task automatic check_frame(input bit sel, input logic [7:0] d, input logic pe, input logic po,
                               output logic [15:0] seen);
        int   f;
        int   idx;
        logic exp_o;
        logic o_out, o_busy, o_done, o_rdy;
        seen = 16'hFFFF;
        f = (1 + 8 + (pe ? 1 : 0) + (sel ? 2 : 1)) * 4;
        for (int n = 1; n <= f + 1; n++) begin
            @(negedge clk);
            o_out  = sel ? d2_tx_out  : tx_out;
            o_busy = sel ? d2_tx_busy : tx_busy;
            o_done = sel ? d2_tx_done : tx_done;
            o_rdy  = sel ? d2_tx_ready : tx_ready;
            idx = (n - 1) / 4;
            if (idx == 0)              exp_o = 1'b0;
            else if (idx <= 8)         exp_o = d[idx-1];
            else if (pe && idx == 9)   exp_o = (^d) ^ po;
            else                       exp_o = 1'b1;
            if ((n - 1) % 4 == 1) seen[idx] = o_out;
            chk($sformatf("tx_out d%0d c%0d", sel, n), 32'(o_out), 32'(exp_o));
            chk($sformatf("tx_busy d%0d c%0d", sel, n), 32'(o_busy), 32'(n <= f));
            chk($sformatf("tx_done d%0d c%0d", sel, n), 32'(o_done), 32'(n == f + 1));
            if (n == 2 || n == f + 1)
                chk($sformatf("tx_ready d%0d c%0d", sel, n), 32'(o_rdy), 32'(n == f + 1));
        end
    endtask

    // One frame with inputs scrambled right after accept.
    task automatic send(input bit sel, input logic [7:0] d, input logic pe, input logic po,
                        output logic [15:0] seen);
        @(negedge clk);
        if (sel) begin
            d2_tx_data = d; d2_parity_en = pe; d2_parity_odd = po; d2_tx_valid = 1'b1;
        end else begin
            tx_data = d; parity_en = pe; parity_odd = po; tx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sel) begin
            d2_tx_valid = 1'b0; d2_tx_data = ~d; d2_parity_en = ~pe; d2_parity_odd = ~po;
        end else begin
            tx_valid = 1'b0; tx_data = ~d; parity_en = ~pe; parity_odd = ~po;
        end
        check_frame(sel, d, pe, po, seen);
        if (sel) d2_parity_en = 1'b0; else parity_en = 1'b0;
    endtask

    logic [15:0] seen;
    int          n_done;
    int          n_low;

    initial begin
        reset_n = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
        d2_tx_data = 8'h00; d2_tx_valid = 1'b0; d2_parity_en = 1'b0; d2_parity_odd = 1'b0;
`ifdef UART_TX_BREAK_EN
        tx_break = 1'b0; d2_tx_break = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #1;
        chk("rst tx_out",   32'(tx_out),   32'd1);
        chk("rst tx_ready", 32'(tx_ready), 32'd1);
        chk("rst tx_busy",  32'(tx_busy),  32'd0);
        chk("rst tx_done",  32'(tx_done),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        send(1'b0, 8'hA5, 1'b0, 1'b0, seen);
        chk("A5 line slots", 32'(seen[9:0]), 32'h34A);

        send(1'b0, 8'h07, 1'b1, 1'b0, seen);
        chk("07 even parity", 32'(seen[9]), 32'd1);
        chk("07 even stop",   32'(seen[10]), 32'd1);
        send(1'b0, 8'h07, 1'b1, 1'b1, seen);
        chk("07 odd parity",  32'(seen[9]), 32'd0);

        // Held valid: second word is taken on the tx_done cycle
        @(negedge clk);
        tx_data = 8'h00; parity_en = 1'b0; parity_odd = 1'b0; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        check_frame(1'b0, 8'h00, 1'b0, 1'b0, seen);
        chk("00 line slots", 32'(seen[9:0]), 32'h200);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(1'b0, 8'hFF, 1'b0, 1'b0, seen);
        chk("FF line slots", 32'(seen[9:0]), 32'h3FE);

        // Reset mid data bit 3
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre-rst bit3 low", 32'(tx_out), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst tx_out",   32'(tx_out),   32'd1);
        chk("mid rst tx_busy",  32'(tx_busy),  32'd0);
        chk("mid rst tx_ready", 32'(tx_ready), 32'd1);
        chk("mid rst tx_done",  32'(tx_done),  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_done = 0; n_low = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_done) n_done++;
            if (!tx_out) n_low++;
        end
        chk("post-rst no done", 32'(n_done), 32'd0);
        chk("post-rst line idle", 32'(n_low), 32'd0);
        send(1'b0, 8'h3C, 1'b0, 1'b0, seen);
        chk("3C line slots", 32'(seen[9:0]), 32'h278);

        send(1'b1, 8'h5A, 1'b0, 1'b0, seen);
        chk("5A two stop slots", 32'(seen[10:0]), 32'h6B4);

`ifdef UART_TX_BREAK_EN
        // Break wins over a simultaneous valid
        @(negedge clk);
        d2_tx_break = 1'b1; d2_tx_data = 8'h55; d2_tx_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 1) d2_tx_valid = 1'b0;
            chk($sformatf("brk tx_out c%0d", n), 32'(d2_tx_out), 32'(n > 20));
            chk($sformatf("brk tx_ready c%0d", n), 32'(d2_tx_ready), 32'(n == 25));
            chk($sformatf("brk tx_busy c%0d", n), 32'(d2_tx_busy), 32'(n <= 24));
            chk($sformatf("brk tx_done c%0d", n), 32'(d2_tx_done), 32'd0);
            if (n == 20) d2_tx_break = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
